// File: rtl/mic1_uart_pkg.sv
// Shared UART definitions for the MIC-1 SoC.
// Used by the RX path and the planned TX rewrite.
package mic1_uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_rx_state_t;

   function automatic int clks_per_bit(
      input int clk_hz,
      input int baud
   );
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/mic1_uart_fifo.sv
// Generic synchronous show-ahead FIFO.
// Head word is visible on dout; reads as zero when empty.
module mic1_uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));

   // A pop on the same edge frees the slot a full push needs.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign dout = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mic1_uart_rx.sv
// 8N1 UART receiver with show-ahead byte FIFO and
// sticky framing/overrun status for the MIC-1 I/O space.
module mic1_uart_rx
   import mic1_uart_pkg::*;
#(
   parameter int CLK_HZ     = 12000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       rd_en,
   input  logic       clr_err,
   output logic [7:0] rd_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       overrun
);

   localparam int CPB  = clks_per_bit(CLK_HZ, BAUD);
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB + 1);
   localparam int BW   = $clog2(DATA_BITS);

   localparam logic [CW-1:0] CNT_BIT  = CW'(CPB - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   uart_rx_state_t       state;
   logic [CW-1:0]        cnt;
   logic [BW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 rx_q1;
   logic                 rx_s;
   logic                 tick;
   logic                 push;
   logic                 ferr_set;
   logic                 ovr_set;
   logic                 fifo_full;
   logic                 fifo_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_q1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         rx_q1 <= rx;
         rx_s  <= rx_q1;
      end
   end

   assign tick     = (cnt == CNT_BIT);
   assign push     = (state == STOP) && tick && rx_s;
   assign ferr_set = (state == STOP) && tick && !rx_s;
   // A pop on the stop-sample edge makes room, so no byte is lost.
   assign ovr_set  = push && fifo_full && !rd_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!rx_s) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            START: begin
               if (cnt == CNT_HALF) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rx_s ? IDLE : DATA;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DATA: begin
               if (tick) begin
                  cnt     <= '0;
                  shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                  bit_idx <= bit_idx + BW'(1);
                  if (bit_idx == LAST_BIT) begin
                     state <= STOP;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            STOP: begin
               if (tick) begin
                  cnt   <= '0;
                  state <= rx_s ? IDLE : BREAK;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            BREAK: begin
               if (rx_s) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (ferr_set) begin
            frame_err <= 1'b1;
         end else if (clr_err) begin
            frame_err <= 1'b0;
         end
         if (ovr_set) begin
            overrun <= 1'b1;
         end else if (clr_err) begin
            overrun <= 1'b0;
         end
      end
   end

   mic1_uart_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (rd_en),
      .din   (shreg),
      .dout  (rd_data),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_mic1_uart_rx.sv
// Self-checking bench for mic1_uart_rx.
// Runs at 16 clocks per bit against a queue-based reference.
module tb_mic1_uart_rx;

   localparam int CPB   = 16;
   localparam int HALF  = CPB / 2;
   localparam int DEPTH = 4;
   // Two sync flops, half-bit start check, then 9 full bit times.
   localparam int STOP_EDGE = 2 + HALF + 9 * CPB;
   localparam int FRAME = 10 * CPB;

   logic       clk;
   logic       rst;
   logic       rx;
   logic       rd_en;
   logic       clr_err;
   logic [7:0] rd_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;

   int total;
   int bad;

   logic [7:0] q[$];
   logic       m_ferr;
   logic       m_ovr;
   logic       vtrace [FRAME];

   mic1_uart_rx #(
      .CLK_HZ     (16),
      .BAUD       (1),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rd_en     (rd_en),
      .clr_err   (clr_err),
      .rd_data   (rd_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_pop();
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic do_clr();
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rx  = 1'b1;
      idle(3);
      rst = 1'b0;
      q.delete();
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      idle(2);
   endtask

   // Drives one whole frame; optionally pops on the stop-sample edge.
   task automatic drive_frame(
      input logic [7:0] d,
      input logic       stop_val,
      input bit         pop_stop
   );
      logic [9:0] f;
      f = {stop_val, d, 1'b0};
      for (int c = 0; c < FRAME; c++) begin
         rx    = f[c / CPB];
         rd_en = pop_stop && (c == STOP_EDGE);
         vtrace[c] = rx_valid;
         @(negedge clk);
      end
      rd_en = 1'b0;
      rx    = 1'b1;
   endtask

   function automatic void m_frame(
      input logic [7:0] d,
      input logic       stop_val,
      input bit         pop
   );
      bit was_full;
      was_full = (q.size() == DEPTH);
      if (pop && q.size() > 0) void'(q.pop_front());
      if (!stop_val) m_ferr = 1'b1;
      else if (was_full && !pop) m_ovr = 1'b1;
      else q.push_back(d);
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      rx  = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(2);
      total++;
      if (rx_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_valid: got %b want 0", rx_valid);
      end
      total++;
      if (rd_data !== 8'h00) begin
         bad++;
         $display("FAIL reset_data: got %h want 00", rd_data);
      end
      total++;
      if (frame_err !== 1'b0 || overrun !== 1'b0) begin
         bad++;
         $display("FAIL reset_flags: got %b%b want 00",
                  frame_err, overrun);
      end
   endtask

   task automatic test_single_byte();
      drive_frame(8'h55, 1'b1, 1'b0);
      total++;
      if (vtrace[STOP_EDGE] !== 1'b0) begin
         bad++;
         $display("FAIL single_early: got %b want 0",
                  vtrace[STOP_EDGE]);
      end
      total++;
      if (vtrace[STOP_EDGE+1] !== 1'b1) begin
         bad++;
         $display("FAIL single_rise: got %b want 1",
                  vtrace[STOP_EDGE+1]);
      end
      total++;
      if (rd_data !== 8'h55) begin
         bad++;
         $display("FAIL single_data: got %h want 55", rd_data);
      end
      total++;
      if (frame_err !== 1'b0 || overrun !== 1'b0) begin
         bad++;
         $display("FAIL single_flags: got %b%b want 00",
                  frame_err, overrun);
      end
      do_pop();
      total++;
      if (rx_valid !== 1'b0 || rd_data !== 8'h00) begin
         bad++;
         $display("FAIL single_pop: got %b/%h want 0/00",
                  rx_valid, rd_data);
      end
   endtask

   task automatic test_glitch();
      rx = 1'b0;
      idle(3);
      rx = 1'b1;
      idle(20);
      total++;
      if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin
         bad++;
         $display("FAIL glitch: got %b/%b want 0/0",
                  rx_valid, frame_err);
      end
      drive_frame(8'h9A, 1'b1, 1'b0);
      total++;
      if (rd_data !== 8'h9A) begin
         bad++;
         $display("FAIL glitch_after: got %h want 9a", rd_data);
      end
      do_pop();
   endtask

   task automatic test_framing();
      drive_frame(8'hA3, 1'b0, 1'b0);
      rx = 1'b0;
      idle(40);
      rx = 1'b1;
      idle(5);
      total++;
      if (frame_err !== 1'b1) begin
         bad++;
         $display("FAIL ferr_set: got %b want 1", frame_err);
      end
      total++;
      if (rx_valid !== 1'b0) begin
         bad++;
         $display("FAIL ferr_empty: got %b want 0", rx_valid);
      end
      drive_frame(8'h3C, 1'b1, 1'b0);
      total++;
      if (rx_valid !== 1'b1 || rd_data !== 8'h3C) begin
         bad++;
         $display("FAIL ferr_next: got %b/%h want 1/3c",
                  rx_valid, rd_data);
      end
      do_clr();
      total++;
      if (frame_err !== 1'b0) begin
         bad++;
         $display("FAIL ferr_clr: got %b want 0", frame_err);
      end
      do_pop();
   endtask

   task automatic test_overrun();
      logic [7:0] exp;
      for (int i = 1; i <= 5; i++) begin
         drive_frame(8'(i), 1'b1, 1'b0);
      end
      total++;
      if (overrun !== 1'b1) begin
         bad++;
         $display("FAIL ovr_set: got %b want 1", overrun);
      end
      for (int i = 1; i <= 4; i++) begin
         exp = 8'(i);
         total++;
         if (rx_valid !== 1'b1 || rd_data !== exp) begin
            bad++;
            $display("FAIL ovr_pop%0d: got %b/%h want 1/%h",
                     i, rx_valid, rd_data, exp);
         end
         do_pop();
      end
      total++;
      if (rx_valid !== 1'b0) begin
         bad++;
         $display("FAIL ovr_drain: got %b want 0", rx_valid);
      end
      do_clr();
      total++;
      if (overrun !== 1'b0) begin
         bad++;
         $display("FAIL ovr_clr: got %b want 0", overrun);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp;
      for (int i = 0; i < 4; i++) begin
         drive_frame(8'h10 + 8'(i), 1'b1, 1'b0);
      end
      drive_frame(8'h14, 1'b1, 1'b1);
      total++;
      if (overrun !== 1'b0) begin
         bad++;
         $display("FAIL simul_ovr: got %b want 0", overrun);
      end
      for (int i = 0; i < 4; i++) begin
         exp = 8'h11 + 8'(i);
         total++;
         if (rx_valid !== 1'b1 || rd_data !== exp) begin
            bad++;
            $display("FAIL simul_pop%0d: got %b/%h want 1/%h",
                     i, rx_valid, rd_data, exp);
         end
         do_pop();
      end
      total++;
      if (rx_valid !== 1'b0) begin
         bad++;
         $display("FAIL simul_drain: got %b want 0", rx_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic [9:0] f;
      drive_frame(8'h77, 1'b1, 1'b0);
      f = {1'b1, 8'hFF, 1'b0};
      for (int c = 0; c < 86; c++) begin
         rx = f[c / CPB];
         @(negedge clk);
      end
      rst = 1'b1;
      idle(2);
      rx = 1'b1;
      rst = 1'b0;
      idle(10);
      total++;
      if (rx_valid !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_empty: got %b want 0", rx_valid);
      end
      drive_frame(8'h42, 1'b1, 1'b0);
      idle(40);
      total++;
      if (rx_valid !== 1'b1 || rd_data !== 8'h42) begin
         bad++;
         $display("FAIL rstmid_data: got %b/%h want 1/42",
                  rx_valid, rd_data);
      end
      do_pop();
      total++;
      if (rx_valid !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_only: got %b want 0", rx_valid);
      end
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic [7:0] exp;
      logic       stop_val;
      bit         pop_stop;
      int         npop;
      do_reset();
      for (int it = 0; it < 16; it++) begin
         d        = 8'($urandom);
         stop_val = ($urandom_range(0, 4) != 0);
         pop_stop = ($urandom_range(0, 2) == 0);
         drive_frame(d, stop_val, pop_stop);
         m_frame(d, stop_val, pop_stop);
         if (!stop_val) begin
            rx = 1'b0;
            idle($urandom_range(0, 30));
            rx = 1'b1;
            idle(3);
         end
         npop = $urandom_range(0, 3);
         for (int p = 0; p < npop; p++) begin
            exp = (q.size() > 0) ? q[0] : 8'h00;
            total++;
            if (rx_valid !== (q.size() > 0) || rd_data !== exp) begin
               bad++;
               $display("FAIL rnd_head%0d: got %b/%h want %b/%h",
                        it, rx_valid, rd_data, q.size() > 0, exp);
            end
            do_pop();
            if (q.size() > 0) void'(q.pop_front());
         end
         total++;
         if (frame_err !== m_ferr || overrun !== m_ovr) begin
            bad++;
            $display("FAIL rnd_flags%0d: got %b%b want %b%b",
                     it, frame_err, overrun, m_ferr, m_ovr);
         end
         if ($urandom_range(0, 3) == 0) begin
            do_clr();
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
         end
      end
      while (q.size() > 0) begin
         exp = q.pop_front();
         total++;
         if (rd_data !== exp) begin
            bad++;
            $display("FAIL rnd_drain: got %h want %h", rd_data, exp);
         end
         do_pop();
      end
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      rst     = 1'b1;
      rx      = 1'b1;
      rd_en   = 1'b0;
      clr_err = 1'b0;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
      @(negedge clk);
      test_reset();
      test_single_byte();
      test_glitch();
      test_framing();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mic1_uart_rx.md
Name: mic1_uart_rx

Overview:
- 8N1 UART receiver feeding the MIC-1 SoC memory-mapped I/O space.
- Converts the icebreaker RX pin into bytes held in a small show-ahead FIFO.
- Reports status bits (data valid, framing error, overrun) that the CPU reads via its I/O register.
- Counterpart to the SoC's TX path; the top level routes board RX to it.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz.
- BAUD, 115200, line rate. CLKS_PER_BIT = CLK_HZ/BAUD (integer division; 104 at defaults). HALF_BIT = CLKS_PER_BIT/2.
- FIFO_DEPTH, 4, received-byte buffer depth. Must be a power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial line, idles high.
- rd_en  in  1  pop strobe from the I/O decoder; one byte per asserted cycle.
- clr_err  in  1  clears the frame_err and overrun sticky flags.
- rd_data  out  8  FIFO head byte (show-ahead); 0x00 when empty.
- rx_valid  out  1  FIFO not empty.
- frame_err  out  1  sticky: a stop bit was sampled low.
- overrun  out  1  sticky: a completed byte was dropped because the FIFO was full.

Behaviour:
- Reset values:
  - FIFO empty; rx_valid=0, rd_data=0x00.
  - frame_err=0, overrun=0.
  - FSM in IDLE; bit counter and shift register 0.
  - Both synchronizer flops set to 1.
- Synchronizer: two flops on rx. The FSM sees only rx_s, two cycles behind the pin.
- FSM states:
  - IDLE: rx_s==0 → START with cnt=0.
  - START: cnt counts 0..HALF_BIT-1. At HALF_BIT-1, if rx_s==0 → DATA with cnt=0, bit=0. Otherwise → IDLE (glitch rejected, no flag).
  - DATA: cnt counts 0..CLKS_PER_BIT-1. At terminal count, shift rx_s into the shift register LSB-first, then bit++. After bit 7 → STOP.
  - STOP: sample at cnt=CLKS_PER_BIT-1.
    - rx_s==1: push byte → IDLE.
    - rx_s==0: set frame_err, discard byte → BREAK.
  - BREAK: wait for rx_s==1 → IDLE. A held-low line produces exactly one frame_err and no further frames.
- Push timing: the byte is written on the stop-sample edge. rx_valid and rd_data update the next cycle.
- FIFO:
  - Pointers wrap modulo FIFO_DEPTH; count has width log2(FIFO_DEPTH)+1.
  - rd_en while empty is ignored; no underflow, no pointer movement.
  - Push while full without rd_en: byte dropped, overrun set, contents unchanged.
  - Push and rd_en in the same cycle while full: both occur, count unchanged, overrun not set.
  - Push and rd_en in the same cycle while empty: push only; the pop is ignored.
- Flags:
  - Flags are sticky until clr_err or rst.
  - If clr_err and a set event occur in the same cycle, set wins.
- Reset mid-frame: the partial byte is discarded, the FSM returns to IDLE, and the FIFO is emptied. If rx is low after reset, the line is treated as a new start edge once rx_s reflects it.
- No parity; 1 stop bit; no baud autodetect.

Decomposition:
- Package mic1_uart_pkg holds:
  - uart_rx_state_t enum: IDLE, START, DATA, STOP, BREAK.
  - Function clks_per_bit(clk_hz, baud).
  - Constant DATA_BITS=8.
  - This package is shared with the future UART TX rewrite.
- Sub-module mic1_uart_fifo is a generic synchronous show-ahead FIFO (WIDTH, DEPTH) with push/pop/full/empty. The FSM, synchronizer and flags live in mic1_uart_rx.

Test Plan:
- All scenarios use CLK_HZ=16 and BAUD=1, giving CLKS_PER_BIT=16 and HALF_BIT=8.
- Single byte: send 0x55 with a valid stop bit. rx_valid rises 1 cycle after the stop sample, rd_data=0x55, flags stay 0. Pulse rd_en: rx_valid=0, rd_data=0x00.
- Glitch reject: drive rx low for 3 cycles, then high. FSM returns to IDLE, rx_valid stays 0, frame_err stays 0.
- Framing error: send 0xA3 with the stop bit low, then hold rx low for 40 cycles, then high. frame_err=1 once, FIFO empty. Then send 0x3C normally: rx_valid=1, rd_data=0x3C. Pulse clr_err: frame_err=0.
- Overrun: send 0x01..0x05 with no reads. overrun=1. Four pops return 0x01, 0x02, 0x03, 0x04 in order, then rx_valid=0.
- Simultaneous push/pop at full: fill with 0x10..0x13, assert rd_en on the stop-sample cycle of 0x14. overrun=0, count stays 4, pops return 0x11, 0x12, 0x13, 0x14.
- Reset mid-frame: assert rst during DATA bit 4 of 0xFF, then send 0x42 after rst releases. Only 0x42 is received; the partial byte never appears.
